// File: rtl/pcileech_com_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// pcileech_com_tx_arbiter_if
//   Bundles the requester-side beat handshake and the COM write path that the
//   TX arbiter sits between.
//
//   req_valid/req_last/req_data : per-requester beat offers (requester i owns
//                                 req_data[i*DATA_WIDTH +: DATA_WIDTH])
//   req_ready                   : per-requester beat accept
//   com_din/com_din_wr_en       : beat and write strobe towards the COM controller
//   com_din_ready               : COM controller can take a beat this cycle
//
//   modport master : arbiter view (drives ready, din, wr_en)
//   modport slave  : environment view (requesters + COM controller)
// ---------------------------------------------------------------------------
interface pcileech_com_tx_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 256
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic [DATA_WIDTH-1:0]         com_din;
  logic                          com_din_wr_en;
  logic                          com_din_ready;

  modport master (
    input  req_valid, req_last, req_data, com_din_ready,
    output req_ready, com_din, com_din_wr_en
  );

  modport slave (
    output req_valid, req_last, req_data, com_din_ready,
    input  req_ready, com_din, com_din_wr_en
  );
endinterface

// File: rtl/pcileech_com_tx_arbiter.sv
// ---------------------------------------------------------------------------
// pcileech_com_tx_arbiter
//   Round-robin, packet-locked arbiter sharing the single COM transmit write
//   path between NUM_REQ internal producers. A grant is taken in an IDLE
//   cycle and held until the last beat of the packet is accepted; a watchdog
//   releases a grant whose owner stops offering beats mid-packet.
//
//   clk, rst    : system clock, synchronous active-high reset
//   bus         : requester handshakes + COM din/wr_en/ready (master modport)
//   grant_id    : index of the grant holder, meaningful while busy
//   busy        : a grant is held
//   err_timeout : one-cycle pulse when the watchdog drops a grant
// ---------------------------------------------------------------------------
module pcileech_com_tx_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int DATA_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  pcileech_com_tx_arbiter_if.master        bus,
  output logic [2:0]                       grant_id,
  output logic                             busy,
  output logic                             err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       grant_id_q, grant_id_d;
  logic [2:0]       last_grant_q, last_grant_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             err_timeout_q, err_timeout_d;

  logic                  g_valid_s;
  logic                  g_last_s;
  logic [DATA_WIDTH-1:0] g_data_s;
  logic [2:0]            winner_s;
  logic                  found_s;
  logic [3:0]            cand_s;
  logic [NUM_REQ-1:0]    req_ready_s;
  logic                  wr_en_s;

  // Select the granted requester's beat; grant_id_q always holds a legal index.
  always_comb begin
    g_valid_s = 1'b0;
    g_last_s  = 1'b0;
    g_data_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == 3'(i)) begin
        g_valid_s = bus.req_valid[i];
        g_last_s  = bus.req_last[i];
        g_data_s  = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        g_valid_s = g_valid_s;
        g_last_s  = g_last_s;
        g_data_s  = g_data_s;
      end
    end
  end

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    winner_s = 3'd0;
    found_s  = 1'b0;
    cand_s   = 4'd0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = {1'b0, last_grant_q} + 4'(i);
      if (cand_s >= 4'(NUM_REQ)) begin
        cand_s = cand_s - 4'(NUM_REQ);
      end else begin
        cand_s = cand_s;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found_s && (cand_s == 4'(j)) && bus.req_valid[j]) begin
          found_s  = 1'b1;
          winner_s = 3'(j);
        end else begin
          found_s  = found_s;
          winner_s = winner_s;
        end
      end
    end
  end

  // Next-state, handshake and watchdog logic.
  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    stall_cnt_d   = stall_cnt_q;
    err_timeout_d = 1'b0;
    req_ready_s   = '0;
    wr_en_s       = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall_cnt_d = '0;
        if (found_s) begin
          grant_id_d = winner_s;
          state_d    = S_GRANT;
        end else begin
          state_d    = S_IDLE;
        end
      end

      S_GRANT: begin
        // Only the holder sees ready; it mirrors COM readiness directly.
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready_s[i] = (grant_id_q == 3'(i)) ? bus.com_din_ready : 1'b0;
        end
        wr_en_s = g_valid_s & bus.com_din_ready;

        if (wr_en_s) begin
          stall_cnt_d = '0;
          if (g_last_s) begin
            state_d      = S_IDLE;
            last_grant_d = grant_id_q;
          end else begin
            state_d      = S_GRANT;
          end
        end else if (!g_valid_s) begin
          // Requester starvation counts; COM backpressure (valid held) does not.
          if (stall_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d       = S_IDLE;
            last_grant_d  = grant_id_q;
            err_timeout_d = 1'b1;
            stall_cnt_d   = '0;
          end else begin
            stall_cnt_d   = stall_cnt_q + CNT_W'(1);
          end
        end else begin
          stall_cnt_d = stall_cnt_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and status registers; reset wins over every same-cycle event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      grant_id_q    <= 3'd0;
      last_grant_q  <= 3'(NUM_REQ - 1);
      stall_cnt_q   <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      stall_cnt_q   <= stall_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign grant_id          = grant_id_q;
  assign busy              = (state_q == S_GRANT);
  assign err_timeout       = err_timeout_q;
  assign bus.req_ready     = req_ready_s;
  assign bus.com_din_wr_en = wr_en_s;
  assign bus.com_din       = g_data_s;

endmodule

// File: tb/tb_pcileech_com_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pcileech_com_tx_arbiter
//   Directed scenarios followed by randomized traffic. A transaction-level
//   model (owner / last owner / stall count) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_pcileech_com_tx_arbiter;
  localparam int NR = 3;
  localparam int DW = 256;
  localparam int TO = 1024;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] grant_id;
  logic       busy;
  logic       err_timeout;

  pcileech_com_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

  pcileech_com_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.master),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  int m_owner = -1;  // -1 : nobody holds the path
  int m_last  = NR - 1;
  int m_stall = 0;
  bit m_err   = 1'b0;

  int n_owner, n_last, n_stall, n_w;
  bit n_err;

  always @(posedge clk) begin
    n_owner = m_owner; n_last = m_last; n_stall = m_stall; n_err = 1'b0;
    if (rst) begin
      n_owner = -1; n_last = NR - 1; n_stall = 0;
    end else if (m_owner < 0) begin
      n_w = -1;
      for (int k = 1; k <= NR; k++)
        if (n_w < 0 && bus.req_valid[(m_last + k) % NR]) n_w = (m_last + k) % NR;
      n_owner = n_w;
    end else if (bus.req_valid[m_owner] && bus.com_din_ready) begin
      n_stall = 0;
      if (bus.req_last[m_owner]) begin n_last = m_owner; n_owner = -1; end
    end else if (!bus.req_valid[m_owner]) begin
      n_stall = m_stall + 1;
      if (n_stall == TO) begin n_last = m_owner; n_owner = -1; n_err = 1'b1; n_stall = 0; end
    end
    m_owner <= n_owner; m_last <= n_last; m_stall <= n_stall; m_err <= n_err;
  end

  // Per-cycle comparison of the DUT against the model.
  logic          e_busy, e_wr;
  logic [NR-1:0] e_rdy;
  always @(negedge clk) begin
    if (chk_en) begin
      e_busy = (m_owner >= 0);
      e_wr   = e_busy && bus.req_valid[m_owner] && bus.com_din_ready;
      e_rdy  = e_busy ? (NR'(bus.com_din_ready) << m_owner) : '0;
      check("busy", busy, e_busy);
      check("wr_en", bus.com_din_wr_en, e_wr);
      check("req_ready", bus.req_ready, e_rdy);
      check("err_timeout", err_timeout, m_err);
      if (e_busy) check("grant_id", grant_id, m_owner);
      if (e_wr) check("com_din", bus.com_din, bus.req_data[m_owner*DW +: DW]);
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [NR-1:0] t_acc, t_rdy;
  logic          t_wr, t_bsy, t_err;
  logic [DW-1:0] t_din;
  logic [2:0]    t_gid;

  // Observe one cycle at its midpoint, then return just after the edge.
  task automatic tick();
    @(negedge clk);
    t_acc = bus.req_valid & bus.req_ready;
    t_rdy = bus.req_ready;
    t_wr  = bus.com_din_wr_en;
    t_din = bus.com_din;
    t_gid = grant_id;
    t_bsy = busy;
    t_err = err_timeout;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic l, input logic [DW-1:0] d);
    bus.req_valid[i] = v;
    bus.req_last[i]  = l;
    bus.req_data[i*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    logic [DW-1:0] r;
    for (int k = 0; k < DW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    #3000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  int n1, last1_cyc, first2, cnt, end_cyc, stall, nerr, post, nwr;
  bit done, xfer, err_busy;
  logic [DW-1:0] got[$];
  logic [DW-1:0] exp_t2[5];
  int rem[NR];

  initial begin
    rst = 1'b1;
    bus.req_valid = '0; bus.req_last = '0; bus.req_data = '0; bus.com_din_ready = 1'b0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    #1;

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_en", bus.com_din_wr_en, 1'b0);
    check("rst_req_ready", bus.req_ready, 3'b000);
    check("rst_err", err_timeout, 1'b0);
    check("rst_grant_id", grant_id, 3'd0);
    @(posedge clk); #1;

    // T1: all three offer a 1-beat packet, grants rotate 0,1,2
    rst = 1'b0;
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, rnd_beat());
    bus.com_din_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t1_wr_pattern", t_wr, k % 2);
      if (k % 2 == 1) check("t1_grant_order", t_gid, k / 2);
      bus.req_valid = bus.req_valid & ~t_acc;
    end

    // T2: 4-beat packet from requester 1 under toggling ready, requester 2 waiting
    set_req(1, 1'b1, 1'b0, DW'(8'h11));
    set_req(2, 1'b1, 1'b1, DW'(8'hAA));
    n1 = 0; last1_cyc = -100; first2 = -1; done = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      tick();
      if (t_wr) got.push_back(t_din);
      if (t_bsy && t_gid == 3'd2 && first2 < 0) first2 = cyc;
      if (t_acc[2]) begin done = 1'b1; bus.req_valid[2] = 1'b0; end
      if (t_acc[1]) begin
        n1++; last1_cyc = cyc;
        if (n1 == 4) bus.req_valid[1] = 1'b0;
        else set_req(1, 1'b1, (n1 == 3), DW'(8'h11 + n1));
      end
      bus.com_din_ready = ~bus.com_din_ready;
    end
    exp_t2 = '{DW'(8'h11), DW'(8'h12), DW'(8'h13), DW'(8'h14), DW'(8'hAA)};
    check("t2_done", done, 1'b1);
    check("t2_beats", got.size(), 5);
    for (int i = 0; i < 5 && i < got.size(); i++) check("t2_beat_order", got[i], exp_t2[i]);
    check("t2_idle_gap", first2, last1_cyc + 2);

    // T3: requester 0 alone, three 2-beat packets back to back
    bus.com_din_ready = 1'b1;
    set_req(0, 1'b1, 1'b0, DW'(8'h30));
    cnt = 0; end_cyc = -1;
    for (int cyc = 0; cyc < 30 && cnt < 6; cyc++) begin
      tick();
      if (t_acc[0]) begin
        cnt++;
        if (cnt == 6) begin bus.req_valid[0] = 1'b0; end_cyc = cyc; end
        else set_req(0, 1'b1, (cnt % 2 == 1), DW'(8'h30 + cnt));
      end
    end
    check("t3_cycles", end_cyc + 1, 9);

    // T4: requester 2 sends one non-last beat then goes silent
    set_req(2, 1'b1, 1'b0, DW'(8'h2A));
    stall = 0; nerr = 0; post = 0; xfer = 1'b0; err_busy = 1'b1;
    for (int cyc = 0; cyc < 1200 && post < 5; cyc++) begin
      tick();
      if (xfer && t_bsy && !t_wr) stall++;
      if (t_acc[2]) begin xfer = 1'b1; bus.req_valid[2] = 1'b0; end
      if (t_err) begin nerr++; err_busy = t_bsy; end
      if (nerr > 0) post++;
    end
    check("t4_stall_cycles", stall, TO);
    check("t4_err_pulses", nerr, 1);
    check("t4_busy_at_err", err_busy, 1'b0);
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, 1'b1, rnd_beat());
    tick();
    bus.req_valid = bus.req_valid & ~t_acc;
    tick();
    check("t4_next_grant", {t_bsy, t_gid}, {1'b1, 3'd0});
    bus.req_valid = bus.req_valid & ~t_acc;
    for (int n = 0; n < 20 && bus.req_valid != '0; n++) begin
      tick();
      bus.req_valid = bus.req_valid & ~t_acc;
    end
    check("t4_drain", bus.req_valid, 3'b000);

    // T5: long COM backpressure mid-packet must not time out
    set_req(0, 1'b1, 1'b0, DW'(8'h50));
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      tick();
      if (t_acc[0]) done = 1'b1;
    end
    check("t5_first_beat", done, 1'b1);
    set_req(0, 1'b1, 1'b1, DW'(8'h51));
    bus.com_din_ready = 1'b0;
    nwr = 0; nerr = 0;
    for (int n = 0; n < 5000; n++) begin
      tick();
      if (t_wr) nwr++;
      if (t_err) nerr++;
    end
    check("t5_no_transfer", nwr, 0);
    check("t5_no_timeout", nerr, 0);
    bus.com_din_ready = 1'b1;
    done = 1'b0;
    for (int n = 0; n < 5 && !done; n++) begin
      tick();
      if (t_acc[0]) begin done = 1'b1; check("t5_last_beat", t_din, DW'(8'h51)); end
    end
    check("t5_completed", done, 1'b1);
    bus.req_valid[0] = 1'b0;

    // T6: reset during beat 2 of a 4-beat packet from requester 1
    set_req(1, 1'b1, 1'b0, DW'(8'h61));
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      tick();
      if (t_acc[1]) done = 1'b1;
    end
    check("t6_first_beat", done, 1'b1);
    set_req(1, 1'b1, 1'b0, DW'(8'h62));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 1'b1, 1'b1, DW'(8'h70));
    tick();
    check("t6_busy_after_rst", t_bsy, 1'b0);
    check("t6_wr_after_rst", t_wr, 1'b0);
    check("t6_ready_after_rst", t_rdy, 3'b000);
    tick();
    check("t6_grant_after_rst", {t_bsy, t_gid}, {1'b1, 3'd0});
    bus.req_valid = bus.req_valid & ~t_acc;
    bus.req_last[1] = 1'b1;
    for (int n = 0; n < 20 && bus.req_valid != '0; n++) begin
      tick();
      bus.req_valid = bus.req_valid & ~t_acc;
    end
    check("t6_drain", bus.req_valid, 3'b000);

    // Random traffic: packets of 1..4 beats, gaps between beats, random ready
    for (int i = 0; i < NR; i++) rem[i] = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (t_acc[i]) begin rem[i]--; bus.req_valid[i] = 1'b0; end
        if (!bus.req_valid[i]) begin
          if (rem[i] == 0 && $urandom_range(3, 0) == 0) rem[i] = $urandom_range(4, 1);
          if (rem[i] > 0 && $urandom_range(2, 0) != 0) set_req(i, 1'b1, (rem[i] == 1), rnd_beat());
        end
      end
      bus.com_din_ready = ($urandom_range(3, 0) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pcileech_com_tx_arbiter.md
Name: pcileech_com_tx_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the single 256-bit COM transmit write path (the FIFO-controller-to-FT601 direction) between several internal requesters: TLP readback, config-space readback, and status/loopback.
- Sits between the per-source producers inside the FIFO controller and the COM controller's din/wr_en/ready interface, on the system clock.
- A grant is held from the first beat of a packet until its last beat is accepted.
- A watchdog reclaims the grant from a requester that stalls mid-packet.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_WIDTH, 256, beat width in bits.
- TIMEOUT_CYCLES, 1024, consecutive requester-stall cycles mid-packet before the grant is forcibly released (power of two, >= 4).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- req_valid  in  NUM_REQ  per-requester beat valid.
- req_last  in  NUM_REQ  per-requester final beat of packet, qualified by req_valid.
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  NUM_REQ  per-requester beat accept.
- com_din  out  DATA_WIDTH  beat to COM controller.
- com_din_wr_en  out  1  beat write strobe to COM controller.
- com_din_ready  in  1  COM controller can accept a beat this cycle.
- grant_id  out  3  index of the current grant holder; valid while busy.
- busy  out  1  a grant is held (state GRANT).
- err_timeout  out  1  one-cycle pulse when the watchdog releases a grant.

Behaviour:
- Single clock domain: clk. Reset: rst is synchronous and active-high.
- Reset values:
  - state=IDLE, busy=0, grant_id=0, err_timeout=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority after reset.
  - stall counter=0.
  - req_ready=0, com_din_wr_en=0.
  - com_din value is don't-care while wr_en=0; it is driven from the granted requester's data.
- FSM with states IDLE and GRANT.
- IDLE:
  - req_ready=0, wr_en=0.
  - If any req_valid is high, choose the first valid requester scanning last_grant+1, last_grant+2, ... modulo NUM_REQ.
  - Registered: grant_id<=winner, state<=GRANT, busy=1 from the next cycle.
  - Arbitration latency: 1 cycle from req_valid to first possible transfer.
- GRANT (combinational datapath, no extra pipeline):
  - com_din = req_data[grant_id].
  - req_ready[grant_id] = com_din_ready; all other req_ready=0.
  - com_din_wr_en = req_valid[grant_id] & com_din_ready.
  - Transfer = com_din_wr_en.
- Transfer with req_last[grant_id]=1:
  - state<=IDLE, last_grant<=grant_id, counter<=0.
  - Exactly one IDLE cycle between packets; re-arbitration happens in that cycle.
- Back-to-back packets from the same requester are allowed only when no other requester is valid in the IDLE cycle (round-robin fairness).
- Single-beat packet (valid & last on the first GRANT beat): GRANT lasts 1 cycle.
- Watchdog:
  - In GRANT, the counter clears on every transfer.
  - It increments when req_valid[grant_id]=0.
  - It holds when req_valid[grant_id]=1 and com_din_ready=0, so COM backpressure never times out.
  - When the counter equals TIMEOUT_CYCLES-1 and increments: state<=IDLE, last_grant<=grant_id, err_timeout=1 for exactly one cycle, counter<=0.
  - No beat transfers on that cycle.
- Non-granted requesters' valid/last/data are ignored and never see ready.
- Requesters must hold valid/data/last stable until ready; the arbiter performs no checking.
- Reset mid-packet: immediate return to reset values on the next edge; any partial packet is truncated (upstream COM framing resynchronises).
- rst has priority over all transitions, including timeout and last-beat events on the same cycle.
- last_grant wrap-around: NUM_REQ-1 -> 0.

Test Plan:
- Post-reset, req_valid=3'b111, each requester sends a 1-beat packet with last=1, com_din_ready=1 -> grants in order 0,1,2; wr_en pattern 0,1,0,1,0,1; grant_id 0,1,2.
- Requester 1 sends a 4-beat packet data 0x11..0x14 while requester 2 is valid throughout; com_din_ready toggles 1,0,1,0... -> the 4 beats appear in order on com_din with no interleaving from requester 2; requester 2 is granted after one IDLE cycle.
- Only requester 0 valid, three consecutive 2-beat packets -> each is granted back-to-back with 1 IDLE cycle between; total 9 cycles from first grant to last beat.
- Requester 2 granted, sends 1 beat with last=0, then drops valid -> after TIMEOUT_CYCLES=1024 stall cycles, err_timeout pulses exactly once and busy=0; the next arbitration starts at requester 0.
- Requester 0 granted mid-packet, com_din_ready held 0 for 5000 cycles with valid=1 -> no timeout, no transfer; the packet completes once ready returns.
- rst asserted for 1 cycle during beat 2 of a 4-beat packet -> next cycle busy=0, all req_ready=0, wr_en=0, last_grant=NUM_REQ-1, so requester 0 wins the next arbitration.
